// File: rtl/adc_parallel_reader.sv
// rtl/adc_parallel_reader.sv - ADC0804-style parallel read controller with one-shot and free-running conversions.
// Optional ADC_AVG4_EN: output the truncated mean of the last four captured samples.
module adc_parallel_reader #(
    parameter int WR_CYC      = 50,
    parameter int RD_CYC      = 30,
    parameter int GAP_CYC     = 200,
    parameter int TIMEOUT_CYC = 4000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_auto_en,
    input  logic       i_adc_intrn,
    input  logic [7:0] i_adc_d,
    output logic       o_adc_csn,
    output logic       o_adc_wrn,
    output logic       o_adc_rdn,
    output logic [7:0] o_sample,
    output logic       o_sample_valid,
    output logic       o_busy,
    output logic       o_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_EOC,
        S_READ,
        S_DONE,
        S_GAP
    } state_t;

    localparam logic [15:0] WR_LAST  = 16'(WR_CYC - 1);
    localparam logic [15:0] RD_LAST  = 16'(RD_CYC - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYC - 1);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_cnt;
    logic        r_intr_meta;
    logic        r_intr_s;
    logic        w_capture;
    logic        w_timeout_evt;
    logic [7:0]  w_sample_next;

    logic        r_adc_csn;
    logic        r_adc_wrn;
    logic        r_adc_rdn;
    logic [7:0]  r_sample;
    logic        r_sample_valid;
    logic        r_busy;
    logic        r_timeout;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_intr_meta <= 1'b1;
            r_intr_s    <= 1'b1;
        end else begin
            r_intr_meta <= i_adc_intrn;
            r_intr_s    <= r_intr_meta;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_capture     = 1'b0;
        w_timeout_evt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start || i_auto_en) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                if (r_cnt == WR_LAST) begin
                    w_next = S_WAIT_EOC;
                end
            end
            S_WAIT_EOC: begin
                // A low intr_s takes priority over an expiring timeout.
                if (!r_intr_s) begin
                    w_next = S_READ;
                end else if (r_cnt == TO_LAST) begin
                    w_next        = S_GAP;
                    w_timeout_evt = 1'b1;
                end
            end
            S_READ: begin
                if (r_cnt == RD_LAST) begin
                    w_next    = S_DONE;
                    w_capture = 1'b1;
                end
            end
            S_DONE: begin
                w_next = S_GAP;
            end
            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Held at zero in IDLE so the only unbounded state never wraps the counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= 16'd0;
        end else if (w_next != r_state || r_state == S_IDLE) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

`ifdef ADC_AVG4_EN
    logic [7:0] r_hist [3];
    logic [9:0] w_sum;

    // The incoming capture is the fourth entry of the averaging window.
    always_comb begin
        w_sum         = 10'(i_adc_d) + 10'(r_hist[0]) + 10'(r_hist[1]) + 10'(r_hist[2]);
        w_sample_next = 8'(w_sum >> 2);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hist[0] <= 8'h00;
            r_hist[1] <= 8'h00;
            r_hist[2] <= 8'h00;
        end else if (w_capture) begin
            r_hist[2] <= r_hist[1];
            r_hist[1] <= r_hist[0];
            r_hist[0] <= i_adc_d;
        end
    end
`else
    always_comb begin
        w_sample_next = i_adc_d;
    end
`endif

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_adc_csn      <= 1'b1;
            r_adc_wrn      <= 1'b1;
            r_adc_rdn      <= 1'b1;
            r_sample       <= 8'h00;
            r_sample_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_adc_csn      <= !(w_next == S_START || w_next == S_READ);
            r_adc_wrn      <= (w_next != S_START);
            r_adc_rdn      <= (w_next != S_READ);
            r_sample_valid <= (w_next == S_DONE);
            r_busy         <= (w_next != S_IDLE);
            r_timeout      <= w_timeout_evt;
            if (w_capture) begin
                r_sample <= w_sample_next;
            end
        end
    end

    assign o_adc_csn      = r_adc_csn;
    assign o_adc_wrn      = r_adc_wrn;
    assign o_adc_rdn      = r_adc_rdn;
    assign o_sample       = r_sample;
    assign o_sample_valid = r_sample_valid;
    assign o_busy         = r_busy;
    assign o_timeout      = r_timeout;

endmodule

// File: tb/tb_adc_parallel_reader.sv
// tb/tb_adc_parallel_reader.sv - randomized self-checking bench for adc_parallel_reader.
module tb_adc_parallel_reader;

    localparam int WR  = 50;
    localparam int RD  = 30;
    localparam int GAP = 200;
    localparam int TO  = 4000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       auto_en = 1'b0;
    logic       adc_intrn = 1'b1;
    logic [7:0] adc_d = 8'h00;
    logic       adc_csn, adc_wrn, adc_rdn;
    logic [7:0] sample;
    logic       sample_valid, busy, timeout;

    adc_parallel_reader #(
        .WR_CYC(WR), .RD_CYC(RD), .GAP_CYC(GAP), .TIMEOUT_CYC(TO)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_auto_en(auto_en),
        .i_adc_intrn(adc_intrn), .i_adc_d(adc_d),
        .o_adc_csn(adc_csn), .o_adc_wrn(adc_wrn), .o_adc_rdn(adc_rdn),
        .o_sample(sample), .o_sample_valid(sample_valid),
        .o_busy(busy), .o_timeout(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ADC behaviour model and its stimulus controls
    int adc_k = 100;
    bit adc_never = 1'b0;
    int data_q[$];
    int sent_q[$];
    int m_ac = 0;
    bit m_armed = 1'b0;
    bit m_prev_wrn = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            adc_intrn = 1'b1;
            m_armed = 1'b0;
            m_ac = 0;
            m_prev_wrn = 1'b1;
        end else begin
            if (!adc_wrn) begin
                adc_intrn = 1'b1;
                m_armed = 1'b1;
                m_ac = 0;
                if (m_prev_wrn && data_q.size() > 0) begin
                    adc_d = 8'(data_q.pop_front());
                    sent_q.push_back(int'(adc_d));
                end
            end else if (m_armed) begin
                m_ac++;
                if (m_ac == adc_k && !adc_never) begin
                    adc_intrn = 1'b0;
                    m_armed = 1'b0;
                end
            end
            if (!adc_rdn) adc_intrn = 1'b1;
            m_prev_wrn = adc_wrn;
        end
    end

    // Bus monitor: strobe run lengths and event times
    int wr_runs[$], rd_runs[$], wr_rise[$];
    int v_cyc[$], v_val[$], to_cyc[$], busy_fall[$];
    int wr_run = 0, rd_run = 0, overlap = 0;
    bit mon_prev_busy = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            wr_run = 0;
            rd_run = 0;
            mon_prev_busy = 1'b0;
        end else begin
            if (!adc_wrn) wr_run++;
            else if (wr_run > 0) begin
                wr_runs.push_back(wr_run);
                wr_rise.push_back(cyc);
                wr_run = 0;
            end
            if (!adc_rdn) rd_run++;
            else if (rd_run > 0) begin
                rd_runs.push_back(rd_run);
                rd_run = 0;
            end
            if (sample_valid) begin
                v_cyc.push_back(cyc);
                v_val.push_back(int'(sample));
            end
            if (timeout) to_cyc.push_back(cyc);
            if (!adc_wrn && !adc_rdn) overlap++;
            if (mon_prev_busy && !busy) busy_fall.push_back(cyc);
            mon_prev_busy = busy;
        end
    end

    // Reference model for the reported sample: raw value or mean of the last four captures
    int m_hist[$];
    int last_exp = 0;

    function automatic int model_out(input int d);
        int s;
`ifdef ADC_AVG4_EN
        m_hist.push_front(d);
        if (m_hist.size() > 4) void'(m_hist.pop_back());
        s = 0;
        foreach (m_hist[i]) s += m_hist[i];
        return s / 4;
`else
        s = d;
        return s;
`endif
    endfunction

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_logs();
        wr_runs.delete(); rd_runs.delete(); wr_rise.delete();
        v_cyc.delete(); v_val.delete(); to_cyc.delete(); busy_fall.delete();
        data_q.delete(); sent_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        chk("idle_within_bound", int'(busy), 0);
    endtask

    task automatic wait_rd_low(input int budget);
        int n = 0;
        while (adc_rdn && n < budget) begin
            step();
            n++;
        end
        chk("rd_low_within_bound", int'(adc_rdn), 0);
    endtask

    task automatic wait_valids(input int cnt, input int budget);
        int n = 0;
        while (v_val.size() < cnt && n < budget) begin
            step();
            n++;
        end
        chk("valids_within_bound", int'(v_val.size() >= cnt), 1);
    endtask

    task automatic check_valids(input int cnt);
        int e;
        chk("valid_count", v_val.size(), cnt);
        for (int i = 0; i < cnt; i++) begin
            e = model_out(qget(sent_q, i));
            chk("sample_value", qget(v_val, i), e);
            last_exp = e;
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_csn", int'(adc_csn), 1);
        chk("rst_wrn", int'(adc_wrn), 1);
        chk("rst_rdn", int'(adc_rdn), 1);
        chk("rst_sample", int'(sample), 0);
        chk("rst_valid", int'(sample_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_timeout", int'(timeout), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        check_reset_outputs();
        rst = 1'b0;
        m_hist.delete();
        last_exp = 0;
        step();
        clear_logs();
    endtask

    initial begin
        int d, k, per;

        do_reset();

        // Single conversion, INTR# 100 cycles after WR# rises
        data_q.push_back(8'hA5);
        adc_k = 100;
        pulse_start();
        wait_idle(2000);
        chk("t1_wr_runs", wr_runs.size(), 1);
        chk("t1_wr_len", qget(wr_runs, 0), WR);
        chk("t1_rd_len", qget(rd_runs, 0), RD);
        check_valids(1);
        chk("t1_eoc_to_valid", qget(v_cyc, 0) - qget(wr_rise, 0), adc_k + 2 + RD);
        chk("t1_gap_len", qget(busy_fall, 0) - qget(v_cyc, 0), GAP + 1);

        // INTR# never asserts
        clear_logs();
        adc_never = 1'b1;
        pulse_start();
        wait_idle(6000);
        chk("t2_timeouts", to_cyc.size(), 1);
        chk("t2_timeout_at", qget(to_cyc, 0) - qget(wr_rise, 0), TO);
        chk("t2_no_valid", v_val.size(), 0);
        chk("t2_sample_kept", int'(sample), last_exp);
        adc_never = 1'b0;

        // INTR# seen on the last timeout cycle: read wins
        clear_logs();
        d = int'($urandom_range(255));
        data_q.push_back(d);
        adc_k = TO - 2;
        pulse_start();
        wait_idle(6000);
        chk("t3_no_timeout", to_cyc.size(), 0);
        check_valids(1);
        chk("t3_eoc_to_valid", qget(v_cyc, 0) - qget(wr_rise, 0), adc_k + 2 + RD);

        // INTR# one cycle too late: timeout
        clear_logs();
        data_q.push_back(int'($urandom_range(255)));
        adc_k = TO - 1;
        pulse_start();
        wait_idle(6000);
        chk("t3b_timeouts", to_cyc.size(), 1);
        chk("t3b_no_valid", v_val.size(), 0);
        chk("t3b_sample_kept", int'(sample), last_exp);

        // Free-running loop
        clear_logs();
        data_q.push_back(8'h10); data_q.push_back(8'h20); data_q.push_back(8'h30);
        adc_k = int'($urandom_range(60, 1));
        auto_en = 1'b1;
        wait_valids(3, 3000);
        auto_en = 1'b0;
        wait_idle(2000);
        check_valids(3);
        per = 1 + WR + (adc_k + 2) + RD + 1 + GAP;
        chk("t4_spacing_a", qget(v_cyc, 1) - qget(v_cyc, 0), per);
        chk("t4_spacing_b", qget(v_cyc, 2) - qget(v_cyc, 1), per);

        // start during READ and during GAP is ignored
        clear_logs();
        data_q.push_back(int'($urandom_range(255)));
        adc_k = int'($urandom_range(80, 1));
        pulse_start();
        wait_rd_low(1000);
        pulse_start();
        wait_valids(1, 1000);
        repeat (5) step();
        pulse_start();
        wait_idle(1000);
        repeat (10) step();
        chk("t5_conversions", wr_runs.size(), 1);
        check_valids(1);
        chk("t5_idle_after", int'(busy), 0);

        // Reset during READ
        clear_logs();
        data_q.push_back(int'($urandom_range(255, 1)));
        pulse_start();
        wait_rd_low(1000);
        repeat (5) step();
        rst = 1'b1;
        step();
        check_reset_outputs();
        rst = 1'b0;
        m_hist.delete();
        last_exp = 0;
        repeat (3) step();
        chk("t6_no_valid", v_val.size(), 0);

        // Averaging sequence (raw values when averaging is off)
        clear_logs();
        data_q.push_back(8'h04); data_q.push_back(8'h08);
        data_q.push_back(8'h0C); data_q.push_back(8'h10);
        adc_k = 20;
        auto_en = 1'b1;
        wait_valids(4, 4000);
        auto_en = 1'b0;
        wait_idle(2000);
        check_valids(4);

        // Randomized single conversions
        for (int it = 0; it < 6; it++) begin
            clear_logs();
            d = int'($urandom_range(255));
            k = int'($urandom_range(300, 1));
            data_q.push_back(d);
            adc_k = k;
            pulse_start();
            wait_idle(3000);
            chk("rnd_wr_len", qget(wr_runs, 0), WR);
            chk("rnd_rd_len", qget(rd_runs, 0), RD);
            check_valids(1);
            chk("rnd_eoc_to_valid", qget(v_cyc, 0) - qget(wr_rise, 0), k + 2 + RD);
        end

        chk("wr_rd_overlap", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
